// File: rtl/flappy_pkg.sv
// flappy_pkg: shared state encoding and widths for the flappy game-flow controller.
package flappy_pkg;
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARM      = 3'd1,
        S_RUN      = 3'd2,
        S_STOPPING = 3'd3,
        S_DEAD     = 3'd4,
        S_ACKING   = 3'd5
    } state_t;
    localparam logic [3:0] SCORE_MAX = 4'd15;
    localparam int STEP_W = 24;
    localparam int HOLD_W = 26;
endpackage

// File: rtl/flappy_step_timer.sv
// flappy_step_timer: loadable down-counter; tick is high while enabled and the count sits at zero.
module flappy_step_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] period,
    output logic         tick
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else if (load) cnt <= period - W'(1);
        else if (en && cnt != '0) cnt <= cnt - W'(1);
    end
    assign tick = en && cnt == '0;
endmodule

// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: sequences the pipe block via start/stop/ack, paces pipe scrolling with a
// score-driven difficulty ramp, and latches win/lose and the high score.
module flappy_game_ctrl import flappy_pkg::*; #(
    parameter int unsigned STEP_DIV = 400000,
    parameter int unsigned HOLD_CYC = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_flap,
    input  logic       collision,
    input  logic [3:0] score,
    input  logic       q_initial,
    input  logic       q_count,
    input  logic       q_stop,
    output logic       start,
    output logic       stop,
    output logic       ack,
    output logic       pipe_step,
    output logic [1:0] level,
    output logic       game_over,
    output logic       win,
    output logic [3:0] high_score
);
    state_t state, next;
    logic step_tick, hold_tick, step_load, hold_load, won;
    logic [STEP_W-1:0] step_period;
    always_comb begin
        next = S_IDLE;
        case (state)
            S_IDLE:     next = btn_flap ? S_ARM : S_IDLE;
            S_ARM:      next = q_count ? S_RUN : S_ARM;
            S_RUN:      next = (collision || score == SCORE_MAX) ? S_STOPPING : S_RUN;
            S_STOPPING: next = q_stop ? S_DEAD : S_STOPPING;
            S_DEAD:     next = (btn_flap && hold_tick) ? S_ACKING : S_DEAD;
            S_ACKING:   next = q_initial ? S_IDLE : S_ACKING;
            default:    next = S_IDLE;
        endcase
    end
    // period follows the live score so a level change lands exactly on a reload
    assign step_period = STEP_W'(STEP_DIV) >> score[3:2];
    assign step_load   = next == S_RUN && (state == S_ARM || step_tick);
    assign hold_load   = next == S_DEAD && state != S_DEAD;
    flappy_step_timer #(.W(STEP_W)) u_step (
        .clk    (clk),
        .reset  (reset),
        .load   (step_load),
        .en     (state == S_RUN),
        .period (step_period),
        .tick   (step_tick)
    );
    flappy_step_timer #(.W(HOLD_W)) u_hold (
        .clk    (clk),
        .reset  (reset),
        .load   (hold_load),
        .en     (state == S_DEAD),
        .period (HOLD_W'(HOLD_CYC)),
        .tick   (hold_tick)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            start      <= 1'b0;
            stop       <= 1'b0;
            ack        <= 1'b0;
            pipe_step  <= 1'b0;
            game_over  <= 1'b0;
            win        <= 1'b0;
            won        <= 1'b0;
            level      <= 2'd0;
            high_score <= 4'd0;
        end else begin
            state     <= next;
            start     <= next == S_ARM;
            stop      <= next == S_STOPPING;
            ack       <= next == S_ACKING;
            pipe_step <= step_tick && next == S_RUN;
            game_over <= next == S_DEAD || next == S_ACKING;
            win       <= (next == S_DEAD || next == S_ACKING) && won;
            level     <= next == S_IDLE ? 2'd0 : step_load ? score[3:2] : level;
            if (state == S_RUN && next == S_STOPPING) won <= !collision && score == SCORE_MAX;
            if (state == S_STOPPING && next == S_DEAD && score > high_score) high_score <= score;
        end
    end
endmodule

// File: tb/tb_flappy_game_ctrl.sv
// tb_flappy_game_ctrl: directed test-plan scenarios then random play, checked every cycle
// against a cycle-count based game model and a one-cycle-latency pipe-block model.
module tb_flappy_game_ctrl;
    localparam int STEP = 8;
    localparam int HOLD = 4;
    localparam int P_IDLE = 0, P_ARM = 1, P_RUN = 2, P_STOP = 3, P_DEAD = 4, P_ACK = 5;

    logic clk = 1'b0;
    logic reset, btn_flap, collision, q_initial, q_count, q_stop;
    logic start, stop, ack, pipe_step, game_over, win;
    logic [3:0] score, high_score;
    logic [1:0] level;

    int cyc = 0, checks = 0, errors = 0;
    bit chk_en = 0;
    int ph, m_level, m_hs, next_step_at, dead_at, pipe;
    bit m_won, e_step;
    logic c_start, c_stop, c_ack;
    int steps[$];
    int exp_steps[11] = '{21, 29, 37, 45, 49, 53, 57, 59, 61, 63, 65};

    always #5 clk = ~clk;

    flappy_game_ctrl #(.STEP_DIV(STEP), .HOLD_CYC(HOLD)) dut (
        .clk(clk), .reset(reset), .btn_flap(btn_flap), .collision(collision), .score(score),
        .q_initial(q_initial), .q_count(q_count), .q_stop(q_stop),
        .start(start), .stop(stop), .ack(ack), .pipe_step(pipe_step), .level(level),
        .game_over(game_over), .win(win), .high_score(high_score)
    );

    task automatic chk(input string name, input logic [31:0] got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    // Game model: advances one cycle using the inputs held during the cycle just ended.
    task automatic advance();
        e_step = 0;
        if (reset) begin
            ph = P_IDLE; m_level = 0; m_hs = 0; m_won = 0;
        end else case (ph)
            P_IDLE: if (btn_flap) ph = P_ARM;
            P_ARM: if (q_count) begin
                ph = P_RUN;
                m_level = int'(score[3:2]);
                next_step_at = cyc + (STEP >> m_level);
            end
            P_RUN: if (collision || score == 4'd15) begin
                ph = P_STOP;
                m_won = !collision;
            end else if (cyc == next_step_at) begin
                e_step = 1;
                m_level = int'(score[3:2]);
                next_step_at = cyc + (STEP >> m_level);
            end
            P_STOP: if (q_stop) begin
                ph = P_DEAD;
                if (int'(score) > m_hs) m_hs = int'(score);
                dead_at = cyc;
            end
            P_DEAD: if (btn_flap && (cyc - 1 - dead_at) >= HOLD - 1) ph = P_ACK;
            P_ACK: if (q_initial) begin
                ph = P_IDLE;
                m_level = 0;
            end
            default: ph = P_IDLE;
        endcase
        if (reset) pipe = 0;
        else if (pipe == 0 && c_start) pipe = 1;
        else if (pipe == 1 && c_stop) pipe = 2;
        else if (pipe == 2 && c_ack) pipe = 0;
        q_initial = (pipe == 0);
        q_count   = (pipe == 1);
        q_stop    = (pipe == 2);
    endtask

    task automatic cycle();
        @(negedge clk);
        if (chk_en) begin
            chk("start", start, int'(ph == P_ARM));
            chk("stop", stop, int'(ph == P_STOP));
            chk("ack", ack, int'(ph == P_ACK));
            chk("pipe_step", pipe_step, int'(e_step));
            chk("level", level, m_level);
            chk("game_over", game_over, int'(ph == P_DEAD || ph == P_ACK));
            chk("win", win, int'((ph == P_DEAD || ph == P_ACK) && m_won));
            chk("high_score", high_score, m_hs);
        end
        c_start = start; c_stop = stop; c_ack = ack;
        @(posedge clk);
        #1;
        cyc++;
        advance();
        chk_en = 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog at cycle %0d: got timeout expected finish", cyc);
        $fatal(1);
    end

    initial begin
        reset = 1; btn_flap = 0; collision = 0; score = 4'd3;
        q_initial = 1; q_count = 0; q_stop = 0; pipe = 0;
        ph = P_IDLE; m_level = 0; m_hs = 0; m_won = 0; e_step = 0; next_step_at = 0; dead_at = 0;
        cycle(); cycle();
        chk("rst_start", start, 0);
        chk("rst_hs", high_score, 0);
        chk("rst_go", game_over, 0);
        reset = 0;
        while (cyc < 10) cycle();
        btn_flap = 1; cycle(); btn_flap = 0;
        chk("start_c11", start, 1);
        cycle(); chk("start_c12", start, 1);
        cycle(); chk("start_c13", start, 0);
        while (cyc < 38) begin cycle(); if (pipe_step === 1'b1) steps.push_back(cyc); end
        score = 4'd4;
        while (cyc < 65) begin
            cycle();
            if (pipe_step === 1'b1) steps.push_back(cyc);
            if (cyc == 54) score = 4'd8;
        end
        chk("step_count", steps.size(), 11);
        foreach (exp_steps[i]) chk("step_cycle", i < steps.size() ? steps[i] : -1, exp_steps[i]);
        chk("level_at_8", level, 2);
        score = 4'd15; collision = 1; cycle(); collision = 0;
        chk("stop_c66", stop, 1);
        while (cyc < 68) cycle();
        chk("dead_go", game_over, 1);
        chk("dead_win_collide", win, 0);
        chk("dead_hs", high_score, 15);
        while (cyc < 70) cycle();
        btn_flap = 1; cycle(); btn_flap = 0;
        chk("hold_ignores_flap", ack, 0);
        cycle();
        btn_flap = 1; cycle(); btn_flap = 0;
        chk("ack_c73", ack, 1);
        cycle(); chk("ack_c74", ack, 1);
        cycle();
        chk("idle_go", game_over, 0);
        chk("idle_ack", ack, 0);
        chk("idle_hs_kept", high_score, 15);
        score = 4'd0;
        btn_flap = 1; cycle(); btn_flap = 0;
        while (cyc < 85) cycle();
        score = 4'd15; cycle();
        while (cyc < 88) cycle();
        chk("lone15_win", win, 1);
        chk("lone15_hs", high_score, 15);
        while (cyc < 92) cycle();
        btn_flap = 1; cycle(); btn_flap = 0;
        while (cyc < 95) cycle();
        chk("idle2_go", game_over, 0);
        score = 4'd0;
        btn_flap = 1; cycle(); btn_flap = 0;
        while (cyc < 101) cycle();
        chk("hs_before_reset", high_score, 15);
        reset = 1; cycle(); reset = 0;
        chk("rst_mid_hs", high_score, 0);
        chk("rst_mid_start", start, 0);
        chk("rst_mid_step", pipe_step, 0);
        chk("rst_mid_go", game_over, 0);
        for (int n = 0; n < 3000; n++) begin
            btn_flap  = ($urandom_range(0, 7) == 0);
            collision = ($urandom_range(0, 59) == 0);
            reset     = ($urandom_range(0, 699) == 0);
            if (ph == P_IDLE) score = 4'd0;
            else if (ph == P_RUN && score != 4'd15 && $urandom_range(0, 9) == 0) score = score + 4'd1;
            cycle();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
